// File: rtl/dm_responder.sv
// Wait-state data memory: one request at a time, byte/half/word loads and stores,
// acknowledged after a fixed number of wait cycles with read data or an error flag.
module dm_responder #(
    parameter int DEPTH = 32,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        INT,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic        op_we, op_uns;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        commit, bad;
    logic [IW-1:0] idx;
    logic [31:0] word, load_val, store_val;
    logic [7:0]  load_b;
    logic [15:0] load_h;
    logic [3:0]  lanes;

    logic [31:0] mem [DEPTH];

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req) next_state = (WAIT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign commit = (next_state == S_RESP) && (state != S_RESP);

    // With zero wait cycles the commit edge is the acceptance edge, so use the live inputs.
    always_comb begin
        op_we    = we_q;
        op_uns   = uns_q;
        op_size  = size_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state == S_IDLE) begin
            op_we    = we;
            op_uns   = uns;
            op_size  = size;
            op_addr  = addr;
            op_wdata = wdata;
        end
    end

    always_comb begin
        bad = (op_size == 2'b11)
            || (op_size == 2'b01 && op_addr[0])
            || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
            || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
        idx    = op_addr[IW+1:2];
        word   = mem[idx];
        load_b = word[{op_addr[1:0], 3'b000} +: 8];
        load_h = word[{op_addr[1], 4'b0000} +: 16];
        load_val  = word;
        store_val = op_wdata;
        lanes     = 4'b1111;
        case (op_size)
            2'b00: begin
                load_val  = op_uns ? {24'b0, load_b} : {{24{load_b[7]}}, load_b};
                store_val = {4{op_wdata[7:0]}};
                lanes     = 4'b0001 << op_addr[1:0];
            end
            2'b01: begin
                load_val  = op_uns ? {16'b0, load_h} : {{16{load_h[15]}}, load_h};
                store_val = {2{op_wdata[15:0]}};
                lanes     = op_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (INT) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && req) begin
                we_q    <= we;
                uns_q   <= uns;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= 4'(WAIT);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err <= bad;
                if (bad)        rdata <= 32'd0;
                else if (!op_we) rdata <= load_val;
            end else begin
                err <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset; contents persist across INT and only a committed store changes them.
    always_ff @(posedge clk) begin
        if (!INT && commit && op_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[idx][8*i +: 8] <= store_val[8*i +: 8];
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign ack  = (state == S_RESP);

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus random accesses
// against a byte-level memory model; a second zero-wait instance covers back-to-back loads.
module tb_dm_responder;

    localparam int DEPTH = 32;
    localparam int WAIT_A = 2;

    logic        clk = 1'b0;
    logic        int_r;
    logic        req_a, we_a, uns_a, req_b, we_b, uns_b;
    logic [1:0]  size_a, size_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic        busy_a, ack_a, err_a, busy_b, ack_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_b   [DEPTH];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A)) dut_a (
        .clk(clk), .INT(int_r), .req(req_a), .we(we_a), .size(size_a), .uns(uns_a),
        .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .ack(ack_a), .err(err_a), .rdata(rdata_a)
    );

    dm_responder #(.DEPTH(DEPTH), .WAIT(0)) dut_b (
        .clk(clk), .INT(int_r), .req(req_b), .we(we_b), .size(size_b), .uns(uns_b),
        .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .ack(ack_b), .err(err_b), .rdata(rdata_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour built byte by byte from the access rules.
    function automatic void model_access(input bit w, input logic [1:0] sz, input bit u,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output bit e, output logic [31:0] rd);
        int nb;
        int wi;
        logic [31:0] v;
        nb = 1 << sz;
        e  = (sz == 2'b11) || ((a % nb) != 0) || ((a >> 2) >= DEPTH);
        wi = int'(a >> 2);
        if (e) begin
            rd = 32'd0;
            last_rd = 32'd0;
        end else if (w) begin
            for (int k = 0; k < nb; k++)
                model_mem[wi][8*(int'(a % 4) + k) +: 8] = d[8*k +: 8];
            rd = last_rd;
        end else begin
            v = 32'd0;
            for (int k = 0; k < nb; k++)
                v[8*k +: 8] = model_mem[wi][8*(int'(a % 4) + k) +: 8];
            if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
            last_rd = v;
        end
    endfunction

    task automatic txn_a(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          n, nbusy;
        model_access(w, sz, u, a, d, exp_err, exp_rd);
        @(negedge clk);
        req_a = 1'b1; we_a = w; size_a = sz; uns_a = u; addr_a = a; wdata_a = d;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        n = 1;
        nbusy = 0;
        while (!ack_a && n < 20) begin
            if (busy_a) nbusy++;
            @(negedge clk);
            n++;
        end
        if (busy_a) nbusy++;
        check({tag, " latency"}, 32'(n), 32'(WAIT_A + 1));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(WAIT_A + 1));
        check({tag, " err"}, {31'b0, err_a}, {31'b0, exp_err});
        check({tag, " rdata"}, rdata_a, exp_rd);
        @(negedge clk);
        check({tag, " ack_one_cycle"}, {30'b0, ack_a, busy_a}, 32'd0);
        check({tag, " err_cleared"}, {31'b0, err_a}, 32'd0);
    endtask

    initial begin
        int          acks, first_c, second_c;
        logic [31:0] got, v, d0, d1;
        bit          e;
        logic [31:0] rd;

        int_r = 1'b1;
        req_a = 1'b1; we_a = 1'b0; size_a = 2'b10; uns_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
        req_b = 1'b1; we_b = 1'b0; size_b = 2'b10; uns_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
        last_rd = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            dut_a.mem[i] = v;
            model_mem[i] = v;
            v = $urandom;
            dut_b.mem[i] = v;
            model_b[i] = v;
        end

        // Reset held with req high
        repeat (2) @(negedge clk);
        check("reset_a", {busy_a, ack_a, err_a}, 3'b000);
        check("reset_rdata_a", rdata_a, 32'd0);
        check("reset_b", {busy_b, ack_b, err_b, rdata_b}, 35'd0);
        int_r = 1'b0; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        check("no_accept_after_reset", {busy_a, ack_a, busy_b, ack_b}, 4'b0000);

        // Word path
        txn_a(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "st_word");
        txn_a(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_word");
        check("ld_word_lit", rdata_a, 32'hDEADBEEF);

        // Byte/half lanes
        dut_a.mem[5] = 32'h0;
        model_mem[5] = 32'h0;
        txn_a(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_0080, "st_byte");
        check("st_byte_word", dut_a.mem[5], 32'h8000_0000);
        txn_a(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, "ld_byte_s");
        check("ld_byte_s_lit", rdata_a, 32'hFFFF_FF80);
        txn_a(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, "ld_byte_u");
        check("ld_byte_u_lit", rdata_a, 32'h0000_0080);
        txn_a(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, "ld_half_s");
        check("ld_half_s_lit", rdata_a, 32'hFFFF_8000);

        // Errors
        txn_a(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, "err_misalign");
        txn_a(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, "err_range");
        check("err_range_word0", dut_a.mem[0], model_mem[0]);
        txn_a(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "err_size");
        txn_a(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, "last_word");

        // req pulsed again during WAIT is ignored
        model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, rd);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; size_a = 2'b10; uns_a = 1'b0; addr_a = 32'h10;
        @(posedge clk);
        @(negedge clk);
        addr_a = 32'h04;
        acks = 0;
        got = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (ack_a) begin acks++; got = rdata_a; end
            if (c == 2) req_a = 1'b0;
            @(negedge clk);
        end
        check("wait_req_one_ack", 32'(acks), 32'd1);
        check("wait_req_rdata", got, rd);

        // Reset one cycle into WAIT aborts a store
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; size_a = 2'b10; addr_a = 32'h20; wdata_a = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        int_r = 1'b1;
        @(negedge clk);
        int_r = 1'b0;
        last_rd = 32'd0;
        check("abort_state", {busy_a, ack_a, err_a, rdata_a}, 35'd0);
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            if (ack_a) acks++;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_no_write", dut_a.mem[8], model_mem[8]);
        txn_a(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "after_abort");

        // Random accesses, some out of range or misaligned
        for (int t = 0; t < 40; t++) begin
            txn_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 35*4 - 1)), $urandom, $sformatf("rnd%0d", t));
        end
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("final_mem%0d", i), dut_a.mem[i], model_mem[i]);

        // Zero-wait instance: back-to-back loads of words 0 and 1
        d0 = model_b[0];
        d1 = model_b[1];
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; size_b = 2'b10; uns_b = 1'b0; addr_b = 32'h0;
        @(posedge clk);
        first_c = 0;
        second_c = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ack_b) begin
                if (first_c == 0) begin
                    first_c = c;
                    check("b_ld0", rdata_b, d0);
                    addr_b = 32'h4;
                end else if (second_c == 0) begin
                    second_c = c;
                    check("b_ld1", rdata_b, d1);
                    req_b = 1'b0;
                end
            end
        end
        req_b = 1'b0;
        check("b_first_ack", 32'(first_c), 32'd1);
        check("b_ack_spacing", 32'(second_c - first_c), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
